sram_port_arbiter: RTL

//  Shares SRAM port A between the network ingress stream and processor accesses.

---
 rtl/sram_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Port A arbiter between the ingress packet stream and the processor; whole-packet
// network grants, capped processor bursts, packet timeout/abort and drop counting.
module sram_port_arbiter #(
   parameter int         DWIDTH      = 72,
   parameter logic [7:0] SOP_CTRL    = 8'hFF,
   parameter logic [7:0] MID_CTRL    = 8'h00,
   parameter int         PROC_BURST  = 4,
   parameter int         PKT_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        net_valid,
   input  logic [7:0]  net_ctrl,
   output logic        net_ready,
   input  logic        proc_req,
   input  logic        proc_we,
   output logic        proc_stall,
   output logic        fifo_sel,
   output logic        port_we,
   output logic        drop_pkt,
   output logic [15:0] drop_cnt,
   output logic        busy
);

   localparam int BW = $clog2(PROC_BURST + 1);
   localparam int TW = $clog2(PKT_TIMEOUT + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(PROC_BURST - 1);
   localparam logic [TW-1:0] TOUT_MAX  = TW'(PKT_TIMEOUT - 1);

   // The ctrl byte sits in the top 8 bits of the data word, so the word must be wider.
   if (DWIDTH < 9) begin : g_bad_dwidth
      $error("sram_port_arbiter: DWIDTH must exceed 8");
   end

   typedef enum logic [1:0] {IDLE, NET, PROC} state_t;

   state_t        state, state_nx;
   logic          last_net, last_net_nx;
   logic          pkt_open, pkt_open_nx;
   logic [BW-1:0] burst, burst_nx;
   logic [TW-1:0] tout, tout_nx;
   logic          drop_nx;
   logic          cnt_inc;
   logic          net_sop;

   assign net_sop  = net_valid && (net_ctrl == SOP_CTRL);
   assign fifo_sel = (state == NET);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         last_net <= 1'b0;
         pkt_open <= 1'b0;
         burst    <= '0;
         tout     <= '0;
         drop_pkt <= 1'b0;
         drop_cnt <= 16'd0;
      end else begin
         state    <= state_nx;
         last_net <= last_net_nx;
         pkt_open <= pkt_open_nx;
         burst    <= burst_nx;
         tout     <= tout_nx;
         drop_pkt <= drop_nx;
         if (cnt_inc && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

   always_comb begin
      state_nx    = state;
      last_net_nx = last_net;
      pkt_open_nx = pkt_open;
      burst_nx    = burst;
      tout_nx     = tout;
      drop_nx     = 1'b0;
      cnt_inc     = 1'b0;
      net_ready   = 1'b0;
      port_we     = 1'b0;
      proc_stall  = 1'b0;
      case (state)
         IDLE: begin
            proc_stall  = proc_req;
            burst_nx    = '0;
            tout_nx     = '0;
            pkt_open_nx = 1'b0;
            // Stray non-SOP words are swallowed and counted, never written.
            if (net_valid && !net_sop) begin
               net_ready = 1'b1;
               cnt_inc   = 1'b1;
            end
            if (net_sop && (!proc_req || !last_net))
               state_nx = NET;
            else if (proc_req)
               state_nx = PROC;
         end
         NET: begin
            net_ready  = 1'b1;
            port_we    = net_valid;
            proc_stall = proc_req;
            if (net_valid) begin
               tout_nx = '0;
               if (net_sop) begin
                  pkt_open_nx = 1'b1;
                  if (pkt_open) begin
                     drop_nx = 1'b1;
                     cnt_inc = 1'b1;
                  end
               end else if (net_ctrl != MID_CTRL) begin
                  state_nx    = IDLE;
                  last_net_nx = 1'b1;
               end
            end else if (tout == TOUT_MAX) begin
               drop_nx  = 1'b1;
               cnt_inc  = 1'b1;
               state_nx = IDLE;
            end else begin
               tout_nx = tout + 1'b1;
            end
         end
         PROC: begin
            port_we = proc_req & proc_we;
            if (!proc_req || (net_valid && (burst == BURST_MAX))) begin
               state_nx    = IDLE;
               last_net_nx = 1'b0;
            end else if (burst != BURST_MAX) begin
               burst_nx = burst + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      // Combinational handshakes must read as idle while reset is held.
      if (reset) begin
         net_ready  = 1'b0;
         port_we    = 1'b0;
         proc_stall = 1'b0;
      end
   end

endmodule
